mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates a single-ported unified memory between the fetch stage (I-side) and the load/store path of the memory stage (D-side). It sits between the pipeline's memory-facing ports and the memory bus. It runs one transaction at a time over a request/grant/response handshake. It returns per-requester stall signals that the hazard unit merges into StallF and the M-stage stall. A watchdog aborts transactions the memory never completes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- TIMEOUT, 255, cycles allowed in REQ+WAIT before abort; minimum 4; counter width is $clog2(TIMEOUT+1)

Ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; address held stable until i_valid
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, registered
- i_valid  out  1  one-cycle completion pulse
- i_err  out  1  qualifies i_valid: transaction timed out
- i_stall  out  1  i_req && !i_valid
- d_req  in  1  load/store request; all d_* inputs held stable until d_valid
- d_we  in  1  1 = store
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- d_valid  out  1  one-cycle completion pulse
- d_err  out  1  qualifies d_valid: transaction timed out
- d_stall  out  1  d_req && !d_valid
- mem_req  out  1  registered bus request
- mem_we  out  1  registered
- mem_be  out  DATA_W/8  registered; all ones for fetches
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  response; acknowledges both reads and writes
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid
- bus_err  out  1  sticky; set on any timeout, cleared only by reset

## Operation
- FSM states and transitions:
  - IDLE to REQ when an eligible request exists. The winner's command is registered onto mem_* and the winner ID is stored.
  - REQ: mem_req=1, command held. mem_gnt moves to WAIT; mem_req=0 from the next cycle.
  - WAIT: mem_rvalid moves to IDLE. Reads capture mem_rdata into the winner's rdata register. The winner's valid pulses the next cycle.
- Eligibility: a requester whose valid is high this cycle is excluded from arbitration in that cycle. This prevents a stale re-issue. The other requester may win.
- Conflict (both eligible): fixed D-side priority, unless round-robin is configured (see Configuration).
- Stores: d_rdata is left unchanged; d_valid pulses on the ack.
- Watchdog:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT: go to IDLE, drop mem_req, and pulse the winner's valid together with its err.
  - A timed-out read loads rdata with 0. bus_err is set.
- mem_rvalid in IDLE or REQ is ignored. After a timeout, a late response is a system error that bus_err already flags.
- mem_gnt outside REQ is ignored.

## Timing
- Reset values:
  - State IDLE.
  - mem_req, mem_we, i_valid, d_valid, i_err, d_err and bus_err are 0.
  - mem_be, mem_addr, mem_wdata, i_rdata and d_rdata are 0.
  - Round-robin pointer set to "I last".
  - Watchdog counter 0.
- Minimum latency, zero-wait memory:
  - Cycle 0: req sampled in IDLE.
  - Cycle 1: mem_req high, gnt received.
  - Cycle 2: mem_rvalid.
  - Cycle 3: valid, and the next arbitration can occur.
- mem_rvalid is never expected in the same cycle as mem_gnt. If it arrives then, it is ignored.
- i_stall and d_stall are combinational and fall in the valid cycle.
- Reset mid-transaction returns to IDLE immediately. mem_req drops asynchronously.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on conflict.
  - A one-bit last-grant pointer updates on every grant.
  - On conflict, the side not granted last wins.
  - After reset, the first conflict goes to D.
- Not defined: D-side always wins on conflict. No pointer logic is built.

## Test plan
- Fetch only, zero-wait memory: i_req=1 at cycle 0, i_addr=0x100, gnt at cycle 1, rvalid at cycle 2 with rdata 0x00500093 -> i_valid=1 and i_rdata=0x00500093 at cycle 3; i_stall=1 during cycles 0-2.
- Simultaneous i_req and d_req (load, d_addr=0x2000), default build -> D issued first, mem_addr=0x2000 at cycle 1. The I transaction issues in the cycle d_valid pulses; mem_addr=i_addr on the following cycle.
- With MEM_ARB_RR_EN, run three back-to-back conflicts -> grants go D, I, D.
- Store: d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF -> mem_we=1, mem_be=0011 and mem_wdata=0xDEADBEEF while mem_req is high; d_rdata unchanged after d_valid.
- Timeout: TIMEOUT=8 and mem_gnt held 0 -> mem_req drops 8 cycles after it rises; i_valid=1 with i_err=1 and i_rdata=0; bus_err=1 and stays 1. A later rvalid in IDLE has no effect.
- Reset mid-WAIT: rst_n=0 -> mem_req=0, all valid/err=0 and state IDLE. After release, a new request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-bus signals of the arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_valid;
  logic                  i_err;
  logic                  i_stall;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_valid;
  logic                  d_err;
  logic                  d_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  bus_err;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output i_rdata, i_valid, i_err, i_stall,
    output d_rdata, d_valid, d_err, d_stall,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output bus_err
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  i_rdata, i_valid, i_err, i_stall,
    input  d_rdata, d_valid, d_err, d_stall,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-at-a-time I/D arbiter for a single-ported memory.
// MEM_ARB_RR_EN selects round-robin on conflict; default is D-side priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t              r_state;
  logic                r_win_d;
  logic [CW-1:0]       r_cnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [BE_W-1:0]     r_mem_be;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_i_valid;
  logic                r_d_valid;
  logic                r_i_err;
  logic                r_d_err;
  logic                r_bus_err;

  logic                w_i_elig;
  logic                w_d_elig;
  logic                w_grant;
  logic                w_pick_d;
  logic                w_busy;
  logic                w_done;
  logic                w_abort;
  logic                w_end;

  // A requester completing this cycle still holds req; skip it to avoid a re-issue.
  assign w_i_elig = bus.i_req && !r_i_valid;
  assign w_d_elig = bus.d_req && !r_d_valid;
  assign w_grant  = w_i_elig || w_d_elig;

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  assign w_pick_d = w_d_elig && (!w_i_elig || !r_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (r_state == S_IDLE && w_grant) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = w_d_elig;
`endif

  assign w_busy  = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_done  = (r_state == S_WAIT) && bus.mem_rvalid;
  assign w_abort = w_busy && (r_cnt == LAST_CNT) && !w_done;
  assign w_end   = w_done || w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_win_d     <= 1'b0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_valid   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_i_err     <= 1'b0;
      r_d_err     <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_i_err   <= 1'b0;
      r_d_err   <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state   <= S_REQ;
            r_win_d   <= w_pick_d;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
            if (w_pick_d) begin
              r_mem_we    <= bus.d_we;
              r_mem_be    <= bus.d_be;
              r_mem_addr  <= bus.d_addr;
              r_mem_wdata <= bus.d_wdata;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_be    <= '1;
              r_mem_addr  <= bus.i_addr;
              r_mem_wdata <= '0;
            end
          end
        end
        S_REQ: begin
          if (w_abort) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (bus.mem_gnt) begin
              r_state   <= S_WAIT;
              r_mem_req <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (w_end) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase

      // Completion or abort: pulse the winner, load read data (0 on abort).
      if (w_end) begin
        if (w_abort) begin
          r_bus_err <= 1'b1;
        end
        if (r_win_d) begin
          r_d_valid <= 1'b1;
          r_d_err   <= w_abort;
          if (!r_mem_we) begin
            r_d_rdata <= w_done ? bus.mem_rdata : '0;
          end
        end else begin
          r_i_valid <= 1'b1;
          r_i_err   <= w_abort;
          r_i_rdata <= w_done ? bus.mem_rdata : '0;
        end
      end
    end
  end

  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_valid   = r_i_valid;
  assign bus.i_err     = r_i_err;
  assign bus.i_stall   = bus.i_req && !r_i_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_valid   = r_d_valid;
  assign bus.d_err     = r_d_err;
  assign bus.d_stall   = bus.d_req && !r_d_valid;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.bus_err   = r_bus_err;
endmodule
